// File: rtl/gx_rst_seq.sv
// Multi-lane transceiver reset sequencer: one TX FSM shared by all lanes, and either one
// RX FSM per lane or one shared RX FSM. Every output is a register decoded from FSM state.
module gx_rst_seq #(
  parameter int LANE_N          = 4,
  parameter int RX_INDEP        = 1,
  parameter int PLL_PD_CYC      = 50,
  parameter int LOCK_STABLE_CYC = 16,
  parameter int TX_DIG_CYC      = 32,
  parameter int RX_ANA_CYC      = 32,
  parameter int LTD_STABLE_CYC  = 16,
  parameter int RX_DIG_CYC      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pll_locked_i,
  input  logic [LANE_N-1:0] tx_cal_busy_i,
  input  logic [LANE_N-1:0] rx_cal_busy_i,
  input  logic [LANE_N-1:0] rx_is_lockedtodata_i,
  output logic              pll_powerdown_o,
  output logic [LANE_N-1:0] tx_analogreset_o,
  output logic [LANE_N-1:0] tx_digitalreset_o,
  output logic [LANE_N-1:0] rx_analogreset_o,
  output logic [LANE_N-1:0] rx_digitalreset_o,
  output logic              tx_ready_o,
  output logic [LANE_N-1:0] rx_ready_o
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC  = max_of(max_of(max_of(PLL_PD_CYC, LOCK_STABLE_CYC), max_of(TX_DIG_CYC, RX_ANA_CYC)),
                                   max_of(LTD_STABLE_CYC, RX_DIG_CYC));
  localparam int CW       = $clog2(MAX_CYC + 1);
  localparam int RX_FSM_N = (RX_INDEP != 0) ? LANE_N : 1;

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;

  typedef enum logic [2:0] {TX_PD, TX_CAL, TX_LOCK, TX_DIG, TX_RDY} tx_state_t;
  typedef enum logic [1:0] {RX_ANA, RX_LTD, RX_DIG, RX_RDY} rx_state_t;

  // CDR lock comes from the recovered-clock domain, so it is double-registered before use.
  logic [LANE_N-1:0] ltd_meta, ltd_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ltd_meta <= '0;
      ltd_sync <= '0;
    end else begin
      // NOTE: non-blocking assignments so each flop samples the pre-edge value of the other.
      ltd_meta <= rx_is_lockedtodata_i;
      ltd_sync <= ltd_meta;
    end
  end

  tx_state_t tx_state, tx_state_n;
  cnt_t      tx_cnt, tx_cnt_n;
  logic      tx_clr, tx_busy;
  logic      tx_pd_d, tx_ana_d, tx_dig_d, tx_rdy_d;
  logic      tx_ana_q, tx_dig_q;

  assign tx_busy = |tx_cal_busy_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state        <= TX_PD;
      tx_cnt          <= '0;
      pll_powerdown_o <= 1'b1;
      tx_ana_q        <= 1'b1;
      tx_dig_q        <= 1'b1;
      tx_ready_o      <= 1'b0;
    end else begin
      tx_state        <= tx_state_n;
      tx_cnt          <= tx_cnt_n;
      pll_powerdown_o <= tx_pd_d;
      tx_ana_q        <= tx_ana_d;
      tx_dig_q        <= tx_dig_d;
      tx_ready_o      <= tx_rdy_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    tx_state_n = tx_state;
    tx_clr     = 1'b0;
    case (tx_state)
      TX_PD:   if (tx_cnt == CW'(PLL_PD_CYC - 1)) tx_state_n = TX_CAL;
      TX_CAL:  if (!tx_busy) tx_state_n = TX_LOCK;
      TX_LOCK: if (!pll_locked_i) tx_clr = 1'b1;
               else if (tx_cnt == CW'(LOCK_STABLE_CYC - 1)) tx_state_n = TX_DIG;
      TX_DIG:  if (!pll_locked_i) tx_state_n = TX_LOCK;
               else if (tx_cnt == CW'(TX_DIG_CYC - 1)) tx_state_n = TX_RDY;
      TX_RDY:  if (!pll_locked_i) tx_state_n = TX_PD;
      default: tx_state_n = TX_PD;
    endcase
    if (tx_state_n != tx_state || tx_clr) tx_cnt_n = '0;
    else if (tx_cnt != CNT_MAX)           tx_cnt_n = tx_cnt + 1'b1;
    else                                  tx_cnt_n = tx_cnt;
  end

  always_comb begin
    tx_pd_d  = (tx_state == TX_PD);
    tx_ana_d = (tx_state == TX_PD) || (tx_state == TX_CAL);
    tx_dig_d = (tx_state != TX_RDY);
    tx_rdy_d = (tx_state == TX_RDY);
  end

  assign tx_analogreset_o  = {LANE_N{tx_ana_q}};
  assign tx_digitalreset_o = {LANE_N{tx_dig_q}};

  logic [RX_FSM_N-1:0] rx_ana_q, rx_dig_q, rx_rdy_q;

  for (genvar g = 0; g < RX_FSM_N; g++) begin : g_rx
    rx_state_t state, state_n;
    cnt_t      cnt, cnt_n;
    logic      lk, bsy, clr;
    logic      ana_d, dig_d, rdy_d, ana_q, dig_q, rdy_q;

    // Shared mode: lock needs every lane, while any lane's busy or loss restarts all.
    if (RX_INDEP != 0) begin : g_lane
      assign lk  = ltd_sync[g];
      assign bsy = rx_cal_busy_i[g];
    end else begin : g_all
      assign lk  = &ltd_sync;
      assign bsy = |rx_cal_busy_i;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state <= RX_ANA;
        cnt   <= '0;
        ana_q <= 1'b1;
        dig_q <= 1'b1;
        rdy_q <= 1'b0;
      end else begin
        state <= state_n;
        cnt   <= cnt_n;
        ana_q <= ana_d;
        dig_q <= dig_d;
        rdy_q <= rdy_d;
      end
    end

    always_comb begin
      state_n = state;
      clr     = 1'b0;
      case (state)
        RX_ANA:  if (cnt >= CW'(RX_ANA_CYC - 1) && !bsy) state_n = RX_LTD;
        RX_LTD:  if (!lk) clr = 1'b1;
                 else if (cnt == CW'(LTD_STABLE_CYC - 1)) state_n = RX_DIG;
        RX_DIG:  if (!lk) state_n = RX_LTD;
                 else if (cnt == CW'(RX_DIG_CYC - 1)) state_n = RX_RDY;
        RX_RDY:  if (bsy) state_n = RX_ANA;
                 else if (!lk) state_n = RX_LTD;
        default: state_n = RX_ANA;
      endcase
      if (state_n != state || clr) cnt_n = '0;
      else if (cnt != CNT_MAX)     cnt_n = cnt + 1'b1;
      else                         cnt_n = cnt;
    end

    always_comb begin
      ana_d = (state == RX_ANA);
      dig_d = (state != RX_RDY);
      rdy_d = (state == RX_RDY);
    end

    assign rx_ana_q[g] = ana_q;
    assign rx_dig_q[g] = dig_q;
    assign rx_rdy_q[g] = rdy_q;
  end

  if (RX_INDEP != 0) begin : g_rx_lanes
    assign rx_analogreset_o  = rx_ana_q;
    assign rx_digitalreset_o = rx_dig_q;
    assign rx_ready_o        = rx_rdy_q;
  end else begin : g_rx_shared
    assign rx_analogreset_o  = {LANE_N{rx_ana_q[0]}};
    assign rx_digitalreset_o = {LANE_N{rx_dig_q[0]}};
    assign rx_ready_o        = {LANE_N{rx_rdy_q[0]}};
  end

endmodule

// File: tb/tb_gx_rst_seq.sv
// Bench for gx_rst_seq: independent, shared-RX and single-lane instances run side by side
// against a phase/elapsed-time reference model, plus timed scenarios and corner sequences.
module tb_gx_rst_seq;
  localparam int PLL_PD_CYC = 50, LOCK_STABLE_CYC = 16, TX_DIG_CYC = 32;
  localparam int RX_ANA_CYC = 32, LTD_STABLE_CYC = 16, RX_DIG_CYC = 32;
  localparam int P_PD = 0, P_CAL = 1, P_LOCK = 2, P_DIG = 3, P_RDY = 4;
  localparam int Q_ANA = 0, Q_LTD = 1, Q_DIG = 2, Q_RDY = 3;

  logic clk_50m = 1'b0;
  always #10 clk_50m = ~clk_50m;

  logic       reset, pll_locked;
  logic [3:0] tx_busy, rx_busy, ltd;

  logic       ind_pd, ind_txr, shr_pd, shr_txr, one_pd, one_txr;
  logic [3:0] ind_txa, ind_txd, ind_rxa, ind_rxd, ind_rxr;
  logic [3:0] shr_txa, shr_txd, shr_rxa, shr_rxd, shr_rxr;
  logic [0:0] one_txa, one_txd, one_rxa, one_rxd, one_rxr;

  gx_rst_seq #(.LANE_N(4), .RX_INDEP(1)) u_ind (
    .clk(clk_50m), .reset(reset), .pll_locked_i(pll_locked),
    .tx_cal_busy_i(tx_busy), .rx_cal_busy_i(rx_busy), .rx_is_lockedtodata_i(ltd),
    .pll_powerdown_o(ind_pd), .tx_analogreset_o(ind_txa), .tx_digitalreset_o(ind_txd),
    .rx_analogreset_o(ind_rxa), .rx_digitalreset_o(ind_rxd), .tx_ready_o(ind_txr), .rx_ready_o(ind_rxr));

  gx_rst_seq #(.LANE_N(4), .RX_INDEP(0)) u_shr (
    .clk(clk_50m), .reset(reset), .pll_locked_i(pll_locked),
    .tx_cal_busy_i(tx_busy), .rx_cal_busy_i(rx_busy), .rx_is_lockedtodata_i(ltd),
    .pll_powerdown_o(shr_pd), .tx_analogreset_o(shr_txa), .tx_digitalreset_o(shr_txd),
    .rx_analogreset_o(shr_rxa), .rx_digitalreset_o(shr_rxd), .tx_ready_o(shr_txr), .rx_ready_o(shr_rxr));

  gx_rst_seq #(.LANE_N(1), .RX_INDEP(1)) u_one (
    .clk(clk_50m), .reset(reset), .pll_locked_i(pll_locked),
    .tx_cal_busy_i(tx_busy[0:0]), .rx_cal_busy_i(rx_busy[0:0]), .rx_is_lockedtodata_i(ltd[0:0]),
    .pll_powerdown_o(one_pd), .tx_analogreset_o(one_txa), .tx_digitalreset_o(one_txd),
    .rx_analogreset_o(one_rxa), .rx_digitalreset_o(one_rxd), .tx_ready_o(one_txr), .rx_ready_o(one_rxr));

  logic [21:0] ind_vec, shr_vec;
  logic [6:0]  one_vec;
  assign ind_vec = {ind_pd, ind_txa, ind_txd, ind_rxa, ind_rxd, ind_rxr, ind_txr};
  assign shr_vec = {shr_pd, shr_txa, shr_txd, shr_rxa, shr_rxd, shr_rxr, shr_txr};
  assign one_vec = {one_pd, one_txa, one_txd, one_rxa, one_rxd, one_rxr, one_txr};

  int n_checks, n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: each sequencer is a phase, cycles elapsed in it and a run of lock samples.
  // Index 0 of tx_* serves the 4-lane instances, index 1 the single-lane one.
  // rx_* indices 0..3 are independent lanes, index 4 the shared sequencer.
  int         tx_ph[2], tx_age[2], tx_run[2];
  logic [3:0] tx_out[2];
  int         rx_ph[5], rx_age[5], rx_run[5];
  logic [2:0] rx_out[5];
  logic [3:0] ltd_hist[$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin tx_ph[i] = P_PD; tx_age[i] = 0; tx_run[i] = 0; tx_out[i] = 4'b1110; end
    for (int i = 0; i < 5; i++) begin rx_ph[i] = Q_ANA; rx_age[i] = 0; rx_run[i] = 0; rx_out[i] = 3'b110; end
    ltd_hist.delete();
    ltd_hist.push_back(4'h0);
    ltd_hist.push_back(4'h0);
  endtask

  task automatic tx_step(input int i, input logic lk, input logic bsy);
    int nxt;
    tx_out[i] = {tx_ph[i] == P_PD, tx_ph[i] <= P_CAL, tx_ph[i] != P_RDY, tx_ph[i] == P_RDY};
    nxt = tx_ph[i];
    case (tx_ph[i])
      P_PD:   if (tx_age[i] + 1 >= PLL_PD_CYC) nxt = P_CAL;
      P_CAL:  if (!bsy) nxt = P_LOCK;
      P_LOCK: begin
        tx_run[i] = lk ? tx_run[i] + 1 : 0;
        if (tx_run[i] >= LOCK_STABLE_CYC) nxt = P_DIG;
      end
      P_DIG:  if (!lk) nxt = P_LOCK; else if (tx_age[i] + 1 >= TX_DIG_CYC) nxt = P_RDY;
      default: if (!lk) nxt = P_PD;
    endcase
    if (nxt != tx_ph[i]) begin tx_ph[i] = nxt; tx_age[i] = 0; tx_run[i] = 0; end
    else tx_age[i]++;
  endtask

  task automatic rx_step(input int i, input logic lk, input logic bsy);
    int nxt;
    rx_out[i] = {rx_ph[i] == Q_ANA, rx_ph[i] != Q_RDY, rx_ph[i] == Q_RDY};
    nxt = rx_ph[i];
    case (rx_ph[i])
      Q_ANA: if (rx_age[i] + 1 >= RX_ANA_CYC && !bsy) nxt = Q_LTD;
      Q_LTD: begin
        rx_run[i] = lk ? rx_run[i] + 1 : 0;
        if (rx_run[i] >= LTD_STABLE_CYC) nxt = Q_DIG;
      end
      Q_DIG: if (!lk) nxt = Q_LTD; else if (rx_age[i] + 1 >= RX_DIG_CYC) nxt = Q_RDY;
      default: if (bsy) nxt = Q_ANA; else if (!lk) nxt = Q_LTD;
    endcase
    if (nxt != rx_ph[i]) begin rx_ph[i] = nxt; rx_age[i] = 0; rx_run[i] = 0; end
    else rx_age[i]++;
  endtask

  task automatic model_edge();
    logic [3:0] seen;
    if (reset) begin
      model_reset();
    end else begin
      seen = ltd_hist.pop_front();
      ltd_hist.push_back(ltd);
      tx_step(0, pll_locked, |tx_busy);
      tx_step(1, pll_locked, tx_busy[0]);
      for (int l = 0; l < 4; l++) rx_step(l, seen[l], rx_busy[l]);
      rx_step(4, &seen, |rx_busy);
    end
  endtask

  task automatic compare_all();
    logic [3:0] ra, rd, rr;
    logic [21:0] ei, es;
    logic [6:0] eo;
    for (int l = 0; l < 4; l++) begin ra[l] = rx_out[l][2]; rd[l] = rx_out[l][1]; rr[l] = rx_out[l][0]; end
    ei = {tx_out[0][3], {4{tx_out[0][2]}}, {4{tx_out[0][1]}}, ra, rd, rr, tx_out[0][0]};
    es = {tx_out[0][3], {4{tx_out[0][2]}}, {4{tx_out[0][1]}},
          {4{rx_out[4][2]}}, {4{rx_out[4][1]}}, {4{rx_out[4][0]}}, tx_out[0][0]};
    eo = {tx_out[1][3], tx_out[1][2], tx_out[1][1], rx_out[0][2], rx_out[0][1], rx_out[0][0], tx_out[1][0]};
    check("model_ind", 32'(ind_vec), 32'(ei));
    check("model_shr", 32'(shr_vec), 32'(es));
    check("model_one", 32'(one_vec), 32'(eo));
  endtask

  task automatic step();
    @(posedge clk_50m);
    model_edge();
    #1;
    compare_all();
  endtask

  // Asserts reset between edges, checks the outputs before any edge, then releases after two edges.
  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    #2;
    compare_all();
    step();
    step();
    reset = 1'b0;
  endtask

  typedef struct packed {
    int busy_lane;
    int busy_until;
    int glitch_edge;
    int exp_pd_high;
    int exp_ana_fall;
    int exp_rdy_rise;
  } scn_t;
  scn_t scn [4];

  task automatic run_scn(input scn_t s, input int idx);
    int pd_high, ana_fall, rdy_rise;
    logic prev_rdy;
    pll_locked = 1'b1; ltd = '1; rx_busy = '0;
    tx_busy = (s.busy_until > 0) ? (4'b0001 << s.busy_lane) : 4'b0000;
    apply_reset();
    pd_high = 0; ana_fall = 0; rdy_rise = 0; prev_rdy = 1'b0;
    for (int e = 1; e <= 260; e++) begin
      pll_locked = !(s.glitch_edge > 0 && e == s.glitch_edge);
      if (e == s.busy_until + 1) tx_busy = '0;
      step();
      if (ind_pd) pd_high++;
      if (ana_fall == 0 && ind_txa == 4'h0) ana_fall = e;
      if (ind_txr && !prev_rdy) rdy_rise = e;
      prev_rdy = ind_txr;
    end
    check($sformatf("scn%0d_pd_high", idx), 32'(pd_high), 32'(s.exp_pd_high));
    check($sformatf("scn%0d_ana_fall", idx), 32'(ana_fall), 32'(s.exp_ana_fall));
    check($sformatf("scn%0d_rdy_rise", idx), 32'(rdy_rise), 32'(s.exp_rdy_rise));
    check($sformatf("scn%0d_rdy_final", idx), 32'(ind_txr), 32'd1);
  endtask

  initial begin
    reset = 1'b0; pll_locked = 1'b1; tx_busy = '0; rx_busy = '0; ltd = '1;
    n_checks = 0; n_err = 0;
    // {busy_lane, busy_until, glitch_edge, pd_high, first tx_analog release, last tx_ready rise}
    scn[0] = '{0,   0,   0,  50,  52, 100};  // baseline
    scn[1] = '{2, 150,   0,  50, 152, 200};  // lane 2 TX cal busy for 100 cycles in TX_CAL
    scn[2] = '{0,   0,  62,  50,  52, 111};  // lock glitch at lock-count 10
    scn[3] = '{0,   0, 120, 100,  52, 220};  // lock glitch while ready: full restart
    #1;
    for (int s = 0; s < 4; s++) run_scn(scn[s], s);

    // Lane 1 CDR lock lost for 5 cycles while every lane is ready.
    pll_locked = 1'b1; ltd = '1; tx_busy = '0; rx_busy = '0;
    apply_reset();
    repeat (120) step();
    check("pre_loss_rdy", 32'(ind_rxr), 32'hF);
    for (int k = 1; k <= 60; k++) begin
      if (k == 1) ltd[1] = 1'b0;
      if (k == 6) ltd[1] = 1'b1;
      step();
      if (k == 3) check("loss_sync_latency", 32'(ind_rxr), 32'hF);
      if (k == 4) begin
        check("loss_ind_rdy", 32'(ind_rxr), 32'b1101);
        check("loss_ind_dig", 32'(ind_rxd), 32'b0010);
        check("loss_ind_ana", 32'(ind_rxa), 32'h0);
        check("loss_tx_rdy", 32'(ind_txr), 32'd1);
        check("loss_shr_rdy", 32'(shr_rxr), 32'h0);
        check("loss_shr_dig", 32'(shr_rxd), 32'hF);
      end
      if (k == 55) begin
        check("recover_ind_early", 32'(ind_rxr), 32'b1101);
        check("recover_shr_early", 32'(shr_rxr), 32'h0);
      end
      if (k == 56) begin
        check("recover_ind", 32'(ind_rxr), 32'hF);
        check("recover_shr", 32'(shr_rxr), 32'hF);
      end
    end

    // Single-lane instance: reset lands while RX is in RX_DIG and must act without a clock edge.
    apply_reset();
    repeat (60) step();
    check("one_in_rx_dig", 32'(one_vec), 32'(7'b0010100));
    reset = 1'b1;
    model_reset();
    #2;
    check("one_async_reset", 32'(one_vec), 32'(7'b1111100));
    step();
    step();
    reset = 1'b0;

    // Randomised soak against the model.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 1999) == 0);
      pll_locked = ($urandom_range(0, 249) != 0);
      for (int l = 0; l < 4; l++) begin
        if ($urandom_range(0, 599) == 0) tx_busy[l] = 1'b1;
        else if ($urandom_range(0, 29) == 0) tx_busy[l] = 1'b0;
        if ($urandom_range(0, 599) == 0) rx_busy[l] = 1'b1;
        else if ($urandom_range(0, 29) == 0) rx_busy[l] = 1'b0;
        if (ltd[l]) ltd[l] = ($urandom_range(0, 199) != 0);
        else ltd[l] = ($urandom_range(0, 5) == 0);
      end
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
